// File: rtl/user_input_queue_pkg.sv
// Shared definitions for the tetris input front end: game event codes,
// key line indices and the key-to-event mapping.
package user_input_queue_pkg;

  localparam logic [2:0] EV_NONE     = 3'd0;
  localparam logic [2:0] EV_LEFT     = 3'd1;
  localparam logic [2:0] EV_RIGHT    = 3'd2;
  localparam logic [2:0] EV_DOWN     = 3'd3;
  localparam logic [2:0] EV_ROTATE   = 3'd4;
  localparam logic [2:0] EV_NEW_GAME = 3'd5;

  localparam int KEY_LEFT     = 0;
  localparam int KEY_RIGHT    = 1;
  localparam int KEY_DOWN     = 2;
  localparam int KEY_ROTATE   = 3;
  localparam int KEY_NEW_GAME = 4;
  localparam int KEY_CNT      = 5;

  // Keys that auto-repeat occupy the low indices 0..REP_KEYS-1.
  localparam int REP_KEYS = 3;

  function automatic logic [2:0] key_to_event(input int idx);
    logic [2:0] ev;
    case (idx)
      KEY_LEFT:     ev = EV_LEFT;
      KEY_RIGHT:    ev = EV_RIGHT;
      KEY_DOWN:     ev = EV_DOWN;
      KEY_ROTATE:   ev = EV_ROTATE;
      KEY_NEW_GAME: ev = EV_NEW_GAME;
      default:      ev = EV_NONE;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/user_input_queue_key_debounce.sv
// One key line: two-flop synchroniser, stability-counter debounce and a
// registered one-cycle press pulse on the debounced 0->1 transition.
module key_debounce
  import user_input_queue_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_q, level_d;
  logic prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synced level disagrees with the accepted level.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    prev_d  = level_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers; reset drops any half-finished debounce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/user_input_queue.sv
// Input stage of the tetris core: debounced keys become pending flags
// (with auto-repeat on left/right/down), a fixed-priority arbiter pushes
// one event per cycle into a show-ahead FIFO read by the game logic.
module user_input_queue
  import user_input_queue_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_i,
  output logic [2:0] user_event_o,
  output logic       user_event_ready_o,
  input  logic       user_event_rd_req_i
);

  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_FIRST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_ONE    = RW'(1);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  logic [KEY_CNT-1:0] level;
  logic [KEY_CNT-1:0] press;
  logic               unused_level;

  logic [RW-1:0]      rep_cnt_q [REP_KEYS];
  logic [RW-1:0]      rep_cnt_d [REP_KEYS];
  logic [KEY_CNT-1:0] rep_fire;

  logic [KEY_CNT-1:0] flag_q, flag_d;
  logic [KEY_CNT-1:0] grant;
  logic [2:0]         push_ev;

  logic [2:0]       mem_q [FIFO_DEPTH];
  logic [2:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;

  logic not_empty;
  logic full;
  logic pop;
  logic push;
  logic can_push;

  for (genvar k = 0; k < KEY_CNT; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (key_i[k]),
      .level_o(level[k]),
      .press_o(press[k])
    );
  end

  assign unused_level = ^level[KEY_NEW_GAME:KEY_ROTATE];

  assign not_empty = (count_q != '0);
  assign full      = (count_q == OCC_FULL);
  assign pop       = user_event_rd_req_i & not_empty;
  assign can_push  = ~full | pop;
  assign push      = |grant;

  // Hold-time counters for repeating keys: first repeat after the delay, then periodic.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < REP_KEYS; i++) begin
      rep_cnt_d[i] = '0;
      if (level[i] && !press[i]) begin
        if (rep_cnt_q[i] == REP_LAST) begin
          rep_fire[i]  = 1'b1;
          rep_cnt_d[i] = REP_RELOAD;
        end else begin
          if (rep_cnt_q[i] == REP_FIRST) begin
            rep_fire[i] = 1'b1;
          end
          rep_cnt_d[i] = rep_cnt_q[i] + REP_ONE;
        end
      end
    end
  end

  // Fixed-priority pick of one pending key whenever the queue can take an entry.
  always_comb begin
    grant   = '0;
    push_ev = EV_NONE;
    if (can_push) begin
      if (flag_q[KEY_NEW_GAME]) begin
        grant[KEY_NEW_GAME] = 1'b1;
      end else if (flag_q[KEY_ROTATE]) begin
        grant[KEY_ROTATE] = 1'b1;
      end else if (flag_q[KEY_LEFT]) begin
        grant[KEY_LEFT] = 1'b1;
      end else if (flag_q[KEY_RIGHT]) begin
        grant[KEY_RIGHT] = 1'b1;
      end else if (flag_q[KEY_DOWN]) begin
        grant[KEY_DOWN] = 1'b1;
      end
    end
    for (int i = 0; i < KEY_CNT; i++) begin
      if (grant[i]) begin
        push_ev = key_to_event(i);
      end
    end
  end

  // Saturating pending flags; a new press or repeat beats the clear from a push.
  always_comb begin
    flag_d = (flag_q & ~grant) | press | rep_fire;
  end

  // Queue storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_ev;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + OCC_ONE;
    end else if (!push && pop) begin
      count_d = count_q - OCC_ONE;
    end
  end

  // State registers; reset empties the queue and forgets all pending work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REP_KEYS; i++) begin
        rep_cnt_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= EV_NONE;
      end
      flag_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      mem_q     <= mem_d;
      flag_q    <= flag_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign user_event_ready_o = not_empty;
  assign user_event_o       = not_empty ? mem_q[rd_ptr_q] : EV_NONE;

endmodule

// File: tb/tb_user_input_queue.sv
// Directed bench for user_input_queue with short debounce/repeat timing.
module tb_user_input_queue;
  import user_input_queue_pkg::*;

  localparam int DEB   = 4;
  localparam int RD    = 20;
  localparam int RP    = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0] keys;
    logic [2:0] exp_ev;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] key_i = '0;
  logic       rd_req = 1'b0;
  logic [2:0] ev;
  logic       ready;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  user_input_queue #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .key_i              (key_i),
    .user_event_o       (ev),
    .user_event_ready_o (ready),
    .user_event_rd_req_i(rd_req)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    key_i  = '0;
    rd_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic tap(input int k);
    key_i[k] = 1'b1;
    idle(8);
    key_i[k] = 1'b0;
    idle(8);
  endtask

  vec_t       vecs [8];
  logic [2:0] all_order [5];
  logic [2:0] sat_order [6];
  int         n;

  initial begin
    vecs[0] = '{5'b00001, EV_LEFT};
    vecs[1] = '{5'b00010, EV_RIGHT};
    vecs[2] = '{5'b00100, EV_DOWN};
    vecs[3] = '{5'b01000, EV_ROTATE};
    vecs[4] = '{5'b10000, EV_NEW_GAME};
    vecs[5] = '{5'b00110, EV_RIGHT};
    vecs[6] = '{5'b11111, EV_NEW_GAME};
    vecs[7] = '{5'b01101, EV_ROTATE};
    all_order = '{EV_NEW_GAME, EV_ROTATE, EV_LEFT, EV_RIGHT, EV_DOWN};
    sat_order = '{EV_LEFT, EV_RIGHT, EV_DOWN, EV_ROTATE, EV_NEW_GAME, EV_LEFT};

    // reset state
    tick();
    check("reset_ready", 32'(ready), 0);
    check("reset_event", 32'(ev), 0);

    // single-pattern latency and priority table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      key_i = vecs[v].keys;
      idle(DEB + 3);
      check($sformatf("vec%0d_ready_early", v), 32'(ready), 0);
      tick();
      check($sformatf("vec%0d_ready", v), 32'(ready), 1);
      check($sformatf("vec%0d_event", v), 32'(ev), 32'(vecs[v].exp_ev));
    end

    // bouncing left tap
    do_reset();
    key_i[0] = 1'b1;
    tick();
    key_i[0] = 1'b0;
    tick();
    key_i[0] = 1'b1;
    idle(7);
    check("bounce_ready_early", 32'(ready), 0);
    tick();
    check("bounce_ready", 32'(ready), 1);
    check("bounce_event", 32'(ev), 32'(EV_LEFT));
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("bounce_pop_ready", 32'(ready), 0);
    check("bounce_pop_event", 32'(ev), 0);
    key_i = '0;
    idle(30);
    check("bounce_single", 32'(ready), 0);

    // rotate held never repeats
    do_reset();
    rd_req = 1'b1;
    key_i[3] = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ready) begin
        n++;
        check("rotate_event", 32'(ev), 32'(EV_ROTATE));
      end
    end
    key_i = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ready) n++;
    end
    check("rotate_count", 32'(n), 1);

    // right held: initial event then repeats after delay and every period
    do_reset();
    rd_req = 1'b1;
    key_i[1] = 1'b1;
    n = 0;
    for (int i = 1; i <= 140; i++) begin
      if (i == 93) key_i = '0;
      tick();
      if (ready) begin
        check($sformatf("right_time%0d", n), 32'(i), (n == 0) ? 32'd8 : 32'(28 + 8 * (n - 1)));
        check("right_event", 32'(ev), 32'(EV_RIGHT));
        n++;
      end
    end
    check("right_count", 32'(n), 10);

    // all keys at once drain in priority order on consecutive cycles
    do_reset();
    rd_req = 1'b1;
    key_i = 5'b11111;
    idle(DEB + 3);
    check("all_ready_early", 32'(ready), 0);
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("all_ready%0d", j), 32'(ready), 1);
      check($sformatf("all_event%0d", j), 32'(ev), 32'(all_order[j]));
    end
    tick();
    check("all_drained", 32'(ready), 0);
    key_i = '0;

    // six presses into a 4-deep queue, then drain with push-on-full-pop
    do_reset();
    tap(0);
    tap(1);
    tap(2);
    tap(3);
    tap(4);
    tap(0);
    idle(10);
    rd_req = 1'b1;
    for (int j = 0; j < 6; j++) begin
      check($sformatf("sat_ready%0d", j), 32'(ready), 1);
      check($sformatf("sat_event%0d", j), 32'(ev), 32'(sat_order[j]));
      tick();
    end
    check("sat_drained", 32'(ready), 0);
    check("sat_drained_event", 32'(ev), 0);
    rd_req = 1'b0;

    // reset with three queued entries and a press mid-debounce
    do_reset();
    tap(0);
    tap(1);
    tap(2);
    idle(4);
    check("rst_pre_ready", 32'(ready), 1);
    check("rst_pre_event", 32'(ev), 32'(EV_LEFT));
    key_i[3] = 1'b1;
    idle(4);
    key_i = '0;
    rst = 1'b1;
    #1;
    check("rst_async_ready", 32'(ready), 0);
    check("rst_async_event", 32'(ev), 0);
    tick();
    tick();
    rst = 1'b0;
    idle(20);
    check("rst_aborted_press", 32'(ready), 0);

    // key held through reset release counts as one press
    rst = 1'b1;
    key_i[4] = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle(DEB + 3);
    check("held_ready_early", 32'(ready), 0);
    tick();
    check("held_ready", 32'(ready), 1);
    check("held_event", 32'(ev), 32'(EV_NEW_GAME));
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    idle(40);
    check("held_single", 32'(ready), 0);
    key_i = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
